// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared constants and helpers for the parametrised register file:
//   - calc_aw(): address width derivation (ceil(log2(depth)), minimum 1)
//   - default WIDTH/DEPTH constants
//   - encodings for the READ_REG and BYPASS mode parameters
package regfile_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 32;

  // READ_REG encodings
  localparam int READ_COMB       = 0;
  localparam int READ_REGISTERED = 1;

  // BYPASS encodings
  localparam int BYPASS_OFF = 0;
  localparam int BYPASS_ON  = 1;

  // Address width for a given depth; a 2-entry file still needs one address bit.
  function automatic int calc_aw(input int depth);
    if (depth <= 2) begin
      return 1;
    end else begin
      return $clog2(depth);
    end
  endfunction

endpackage

// File: rtl/regfile_param_register_n.sv
// register_n
//   WIDTH-bit D flip-flop with enable, synchronous clear and asynchronous
//   active-low reset. Used for every register-file entry and for the
//   optional read-data registers.
//   Ports:
//     i_clk   - rising-edge clock
//     i_rst_n - asynchronous active-low reset (q -> 0)
//     i_clr   - synchronous clear (q -> 0), overrides i_en
//     i_en    - load enable
//     i_d     - data in
//     o_q     - registered data out
module register_n
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Storage: reset and clear both force zero; clear wins over a load.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/regfile_param.sv
// regfile_param
//   Parametrised register file: one synchronous write port, two read ports,
//   optional hard-wired zero entry, optional write-to-read bypass, optional
//   registered reads, synchronous bulk clear and a per-entry dirty vector.
//   Ports:
//     clk, rst_n          - clock, asynchronous active-low reset
//     clr                 - synchronous clear of all entries and dirty
//     wr_en/addr/data     - write port
//     ra_addr / ra_data   - read port A
//     rb_addr / rb_data   - read port B
//     dirty               - bit i set once entry i is written after reset/clr
module regfile_param
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = BYPASS_ON,
  parameter int READ_REG = READ_COMB,
  localparam int AW      = calc_aw(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    ra_addr,
  output logic [WIDTH-1:0] ra_data,
  input  logic [AW-1:0]    rb_addr,
  output logic [WIDTH-1:0] rb_data,
  output logic [DEPTH-1:0] dirty
);

  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  logic             w_wr_in_range;
  logic             w_wr_zero_hit;
  logic             w_wr_commit;
  logic [DEPTH-1:0] w_wr_sel;
  logic [WIDTH-1:0] w_mem [DEPTH];
  logic [WIDTH-1:0] w_ra_array;
  logic [WIDTH-1:0] w_rb_array;
  logic [WIDTH-1:0] w_ra_next;
  logic [WIDTH-1:0] w_rb_next;
  logic             w_ra_fwd;
  logic             w_rb_fwd;
  logic [DEPTH-1:0] r_dirty;

  assign w_wr_in_range = ({{(32-AW){1'b0}}, wr_addr} < DEPTH_U);
  assign w_wr_zero_hit = (ZERO_REG != 0) && (wr_addr == '0);
  // rst_n is included so that the combinational bypass path cannot leak
  // write data onto the read ports while the file is held in reset.
  assign w_wr_commit   = rst_n && wr_en && !clr && w_wr_in_range && !w_wr_zero_hit;

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_entry
      assign w_wr_sel[g] = w_wr_commit && (wr_addr == AW'(g));

      register_n #(.WIDTH(WIDTH)) u_entry (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_clr   (clr),
        .i_en    (w_wr_sel[g]),
        .i_d     (wr_data),
        .o_q     (w_mem[g])
      );
    end
  endgenerate

  // Read muxes: one-hot OR over all entries, so an address >= DEPTH matches
  // nothing and reads 0. The zero entry never loads, so it reads 0 as well.
  always_comb begin
    w_ra_array = '0;
    w_rb_array = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_ra_array = w_ra_array | ((ra_addr == AW'(i)) ? w_mem[i] : '0);
      w_rb_array = w_rb_array | ((rb_addr == AW'(i)) ? w_mem[i] : '0);
    end
  end

  assign w_ra_fwd  = (BYPASS == BYPASS_ON) && w_wr_commit && (ra_addr == wr_addr);
  assign w_rb_fwd  = (BYPASS == BYPASS_ON) && w_wr_commit && (rb_addr == wr_addr);
  assign w_ra_next = w_ra_fwd ? wr_data : w_ra_array;
  assign w_rb_next = w_rb_fwd ? wr_data : w_rb_array;

  generate
    if (READ_REG == READ_REGISTERED) begin : g_rd_reg
      register_n #(.WIDTH(WIDTH)) u_ra_reg (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_clr   (clr),
        .i_en    (1'b1),
        .i_d     (w_ra_next),
        .o_q     (ra_data)
      );

      register_n #(.WIDTH(WIDTH)) u_rb_reg (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_clr   (clr),
        .i_en    (1'b1),
        .i_d     (w_rb_next),
        .o_q     (rb_data)
      );
    end else begin : g_rd_comb
      assign ra_data = w_ra_next;
      assign rb_data = w_rb_next;
    end
  endgenerate

  // Dirty tracking: set on a committed write, cleared by reset or clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dirty <= '0;
    end else if (clr) begin
      r_dirty <= '0;
    end else begin
      r_dirty <= r_dirty | w_wr_sel;
    end
  end

  assign dirty = r_dirty;

endmodule

// File: tb/tb_regfile_param.sv
// Testbench for regfile_param: five instances with different parameter sets
// share one stimulus stream; a vector table checks them cycle by cycle,
// followed by hand-written out-of-range and asynchronous-reset sequences.
module tb_regfile_param;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  ra_addr;
  logic [4:0]  rb_addr;

  // u0: defaults (ZERO_REG=1, BYPASS=1, READ_REG=0, DEPTH=32)
  logic [31:0] u0_ra, u0_rb, u0_dirty;
  // u1: ZERO_REG=0, BYPASS=0, READ_REG=0
  logic [31:0] u1_ra, u1_rb, u1_dirty;
  // u2: BYPASS=1, READ_REG=1
  logic [31:0] u2_ra, u2_rb, u2_dirty;
  // u3: BYPASS=0, READ_REG=1
  logic [31:0] u3_ra, u3_rb, u3_dirty;
  // u4: DEPTH=20, BYPASS=1, READ_REG=0
  logic [31:0] u4_ra, u4_rb;
  logic [19:0] u4_dirty;

  int checks = 0;
  int errors = 0;

  regfile_param u0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .ra_addr(ra_addr), .ra_data(u0_ra), .rb_addr(rb_addr),
    .rb_data(u0_rb), .dirty(u0_dirty)
  );

  regfile_param #(.ZERO_REG(0), .BYPASS(0), .READ_REG(0)) u1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .ra_addr(ra_addr), .ra_data(u1_ra), .rb_addr(rb_addr),
    .rb_data(u1_rb), .dirty(u1_dirty)
  );

  regfile_param #(.ZERO_REG(1), .BYPASS(1), .READ_REG(1)) u2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .ra_addr(ra_addr), .ra_data(u2_ra), .rb_addr(rb_addr),
    .rb_data(u2_rb), .dirty(u2_dirty)
  );

  regfile_param #(.ZERO_REG(1), .BYPASS(0), .READ_REG(1)) u3 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .ra_addr(ra_addr), .ra_data(u3_ra), .rb_addr(rb_addr),
    .rb_data(u3_rb), .dirty(u3_dirty)
  );

  regfile_param #(.DEPTH(20), .ZERO_REG(1), .BYPASS(1), .READ_REG(0)) u4 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .ra_addr(ra_addr), .ra_data(u4_ra), .rb_addr(rb_addr),
    .rb_data(u4_rb), .dirty(u4_dirty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Comb expectations (u0/u1/u4) hold before the edge; registered ones
  // (u2/u3) and dirty after the edge of the same vector.
  typedef struct {
    logic        clr;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] e0a;
    logic [31:0] e0b;
    logic [31:0] e1a;
    logic [31:0] e4a;
    logic [31:0] e2a;
    logic [31:0] e3a;
    logic [31:0] edirty;
  } vec_t;

  vec_t vecs [11];

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 5'd7,  32'hDEADBEEF, 5'd7,  5'd7,
                 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'h0000_0080};
    vecs[1]  = '{1'b0, 1'b0, 5'd7,  32'h0, 5'd7,  5'd0,
                 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0000_0080};
    vecs[2]  = '{1'b0, 1'b1, 5'd0,  32'h12345678, 5'd0,  5'd7,
                 32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_0080};
    vecs[3]  = '{1'b0, 1'b0, 5'd0,  32'h0, 5'd0,  5'd7,
                 32'h0, 32'hDEADBEEF, 32'h12345678, 32'h0, 32'h0, 32'h0, 32'h0000_0080};
    vecs[4]  = '{1'b0, 1'b1, 5'd3,  32'h1, 5'd3,  5'd3,
                 32'h1, 32'h1, 32'h0, 32'h1, 32'h1, 32'h0, 32'h0000_0088};
    vecs[5]  = '{1'b0, 1'b1, 5'd3,  32'hA5A5A5A5, 5'd3,  5'd3,
                 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h1, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h1, 32'h0000_0088};
    vecs[6]  = '{1'b0, 1'b0, 5'd3,  32'h0, 5'd3,  5'd3,
                 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0000_0088};
    vecs[7]  = '{1'b1, 1'b1, 5'd9,  32'h0000FFFF, 5'd9,  5'd3,
                 32'h0, 32'hA5A5A5A5, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[8]  = '{1'b0, 1'b0, 5'd9,  32'h0, 5'd9,  5'd3,
                 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[9]  = '{1'b0, 1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd30,
                 32'hCAFEF00D, 32'h0, 32'h0, 32'h0, 32'hCAFEF00D, 32'h0, 32'h8000_0000};
    vecs[10] = '{1'b0, 1'b0, 5'd31, 32'h0, 5'd31, 5'd31,
                 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D, 32'h8000_0000};

    // Reset: make a real falling edge, hold reset with addresses applied.
    rst_n   = 1'b1;
    clr     = 1'b0;
    wr_en   = 1'b0;
    wr_addr = 5'd0;
    wr_data = 32'h0;
    ra_addr = 5'd5;
    rb_addr = 5'd31;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_u0_ra", u0_ra, 32'h0);
    chk("rst_u0_rb", u0_rb, 32'h0);
    chk("rst_u2_ra", u2_ra, 32'h0);
    chk("rst_u0_dirty", u0_dirty, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_u0_ra", u0_ra, 32'h0);
    chk("idle_u2_rb", u2_rb, 32'h0);
    chk("idle_u0_dirty", u0_dirty, 32'h0);

    // Table-driven main sequence.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      clr     = vecs[i].clr;
      wr_en   = vecs[i].we;
      wr_addr = vecs[i].wa;
      wr_data = vecs[i].wd;
      ra_addr = vecs[i].ra;
      rb_addr = vecs[i].rb;
      #2;
      chk($sformatf("v%0d_u0_ra", i), u0_ra, vecs[i].e0a);
      chk($sformatf("v%0d_u0_rb", i), u0_rb, vecs[i].e0b);
      chk($sformatf("v%0d_u1_ra", i), u1_ra, vecs[i].e1a);
      chk($sformatf("v%0d_u4_ra", i), u4_ra, vecs[i].e4a);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_u2_ra", i), u2_ra, vecs[i].e2a);
      chk($sformatf("v%0d_u3_ra", i), u3_ra, vecs[i].e3a);
      if (vecs[i].ra == vecs[i].rb) begin
        chk($sformatf("v%0d_u2_rb", i), u2_rb, vecs[i].e2a);
        chk($sformatf("v%0d_u3_rb", i), u3_rb, vecs[i].e3a);
      end
      chk($sformatf("v%0d_u0_dirty", i), u0_dirty, vecs[i].edirty);
    end

    // Out of range on the 20-entry instance.
    @(negedge clk);
    clr = 1'b0; wr_en = 1'b1; wr_addr = 5'd25; wr_data = 32'h00000055;
    ra_addr = 5'd25; rb_addr = 5'd5;
    #2;
    chk("oor_u4_ra_bypass", u4_ra, 32'h0);
    chk("oor_u4_rb_alias", u4_rb, 32'h0);
    @(posedge clk);
    #1;
    chk("oor_u4_dirty", {12'h0, u4_dirty}, 32'h0);
    @(negedge clk);
    wr_en = 1'b0; ra_addr = 5'd25; rb_addr = 5'd9;
    #2;
    chk("oor_u4_ra_after", u4_ra, 32'h0);
    chk("oor_u4_rb_alias9", u4_rb, 32'h0);
    chk("oor_u0_ra_inrange", u0_ra, 32'h00000055);

    // Asynchronous reset between edges, with a write pending.
    @(negedge clk);
    ra_addr = 5'd31; rb_addr = 5'd31;
    @(posedge clk);
    #1;
    chk("pre_rst_u2_ra", u2_ra, 32'hCAFEF00D);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h0BADF00D;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_u0_ra", u0_ra, 32'h0);
    chk("arst_u2_ra", u2_ra, 32'h0);
    chk("arst_u3_rb", u3_rb, 32'h0);
    chk("arst_u0_dirty", u0_dirty, 32'h0);
    @(negedge clk);
    wr_en = 1'b0;
    rst_n = 1'b1;
    #2;
    chk("post_rst_u0_ra", u0_ra, 32'h0);
    chk("post_rst_u1_rb", u1_rb, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised multi-port register file for the CPU datapath: one synchronous write port, two read ports, and a configurable word width and depth. Supports an optional hard-wired zero register, write-to-read bypass, optional registered reads, a synchronous bulk clear, and a per-entry "written since clear" vector. It replaces fixed 32x32 register arrays built from per-bit flip-flops, and sits between instruction decode and the ALU.

## Interface
Parameters:
- WIDTH, 32, bits per entry (1..64)
- DEPTH, 32, number of entries (2..256; need not be a power of two)
- ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes
- BYPASS, 1, 1 = forward same-cycle write data to matching read ports
- READ_REG, 0, 0 = combinational read; 1 = read data registered (1-cycle latency)

Ports (AW = max(1, $clog2(DEPTH))):
- clk  in  1  rising-edge clock, sole clock domain
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear of all entries and of dirty
- wr_en  in  1  write strobe
- wr_addr  in  AW  write address
- wr_data  in  WIDTH  write data
- ra_addr  in  AW  read port A address
- ra_data  out  WIDTH  read port A data
- rb_addr  in  AW  read port B address
- rb_data  out  WIDTH  read port B data
- dirty  out  DEPTH  bit i = 1 when entry i has been written since the last reset or clr

## Operation
- Write commits at the rising edge of clk when wr_en=1, wr_addr<DEPTH, and not (ZERO_REG and wr_addr==0).
- Writes with wr_addr>=DEPTH are dropped silently. Reads with addr>=DEPTH return 0.
- ZERO_REG=1: a read of address 0 returns 0. dirty[0] stays 0.
- A committed write sets dirty[wr_addr].
- clr=1 zeroes all entries and dirty at the edge. clr has priority: a write in the same cycle is dropped.
- Bypass (BYPASS=1): if a read address equals an effective write address this cycle (write would commit, clr=0), that port sees wr_data instead of the stored value. The effective read value is the array value after this cycle's write.
- BYPASS=0: a read sees the pre-write value in the same cycle. With READ_REG=1, the registered output therefore shows the old value.
- Both read ports are independent. They may read the same address, including the write address.

## Timing
- Reset (rst_n=0, asynchronous): all entries = 0, dirty = 0. With READ_REG=1, ra_data and rb_data = 0 immediately. With READ_REG=0, outputs follow addresses and read 0.
- Reset deassertion is taken synchronously. The first write can commit at the first rising edge with rst_n=1.
- READ_REG=0: read latency 0. Address to data is a combinational path, including the bypass mux.
- READ_REG=1: data for an address presented in cycle N appears in cycle N+1. The sample uses the bypass rule of cycle N.
- Write latency: data is visible via the array on the cycle after the write edge. With BYPASS=1 and READ_REG=0, it is also visible in the same cycle.
- clr with READ_REG=1: read registers capture 0 at the clr edge.
- Reset mid-write: the write is lost, and every entry reads 0.

## Structure
- Package regfile_pkg holds:
  - the AW derivation function (clog2 with minimum 1);
  - the default WIDTH and DEPTH constants;
  - the READ_REG and BYPASS mode encodings.
- Sub-module register_n: WIDTH-bit D flip-flop with enable and async active-low reset. It is instantiated once per entry via a generate loop and reused for the two optional read-data registers.
- The dirty vector and read muxes live in the top level.

## Test plan
- Reset then read: hold rst_n=0 and drive ra_addr=5, rb_addr=31 → ra_data=0, rb_data=0, dirty=0. Release and idle 3 cycles → still 0.
- Basic write/read (READ_REG=0, BYPASS=0): write 0xDEADBEEF to addr 7 at edge N → ra_addr=7 reads 0xDEADBEEF from cycle N+1, and dirty[7]=1.
- Zero register: write 0x12345678 to addr 0 → ra_addr=0 reads 0, dirty[0]=0. Repeat with ZERO_REG=0 → reads 0x12345678.
- Bypass and registered read: with BYPASS=1, READ_REG=1, write 0xA5A5A5A5 to addr 3 while ra_addr=rb_addr=3 (previously 0x1) → both ports show 0xA5A5A5A5 the next cycle. With BYPASS=0 they show 0x1.
- clr versus write: assert clr and wr_en to addr 9 with 0xFFFF in the same cycle → all entries read 0 and dirty=0.
- Out of range and async reset: with DEPTH=20, write addr 25 → no entry changes, and a read of addr 25 returns 0. Then pull rst_n low between edges → outputs go to 0 without waiting for a clock edge.
